// File: rtl/mem_block_mover.sv
// rtl/mem_block_mover.sv - copy/fill block mover driving a single-port memory
module mem_block_mover #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [4:0]        length,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [4:0]        words_done,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [4:0]        len_r;
  logic [4:0]        i;
  logic [4:0]        eff_len;
  logic [4:0]        i_nxt;
  logic              last;

  assign eff_len = (length > 5'd16) ? 5'd16 : length;
  assign i_nxt   = i + 5'd1;
  assign last    = (i_nxt == len_r);

  // Outputs are registered for the state being entered. mem_write_data doubles
  // as the copy buffer (captured in RD) and as the latched fill value in FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      src_r          <= '0;
      dst_r          <= '0;
      len_r          <= '0;
      i              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      words_done     <= '0;
      mem_write_en   <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_r      <= src_addr;
            dst_r      <= dst_addr;
            len_r      <= eff_len;
            i          <= '0;
            words_done <= '0;
            if (eff_len == 5'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (mode) begin
              state          <= FILL;
              busy           <= 1'b1;
              mem_write_en   <= 1'b1;
              mem_addr       <= dst_addr;
              mem_write_data <= fill_data;
            end else begin
              state    <= RD;
              busy     <= 1'b1;
              mem_addr <= src_addr;
            end
          end
        end
        RD: begin
          state          <= WR;
          mem_write_en   <= 1'b1;
          mem_addr       <= dst_r + ADDR_W'(i);
          mem_write_data <= mem_read_data;
        end
        WR: begin
          i              <= i_nxt;
          words_done     <= words_done + 5'd1;
          mem_write_en   <= 1'b0;
          mem_write_data <= '0;
          if (last) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            mem_addr <= '0;
          end else begin
            state    <= RD;
            mem_addr <= src_r + ADDR_W'(i_nxt);
          end
        end
        FILL: begin
          i          <= i_nxt;
          words_done <= words_done + 5'd1;
          if (last) begin
            state          <= DONE;
            busy           <= 1'b0;
            done           <= 1'b1;
            mem_write_en   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
          end else begin
            mem_addr <= dst_r + ADDR_W'(i_nxt);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// tb/tb_mem_block_mover.sv - randomized bench for mem_block_mover against an array model
module tb_mem_block_mover;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] src_addr = '0;
  logic [3:0] dst_addr = '0;
  logic [4:0] length = '0;
  logic [7:0] fill_data = '0;
  logic       busy, done, mem_write_en;
  logic [4:0] words_done;
  logic [3:0] mem_addr;
  logic [7:0] mem_write_data, mem_read_data;

  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  int n_vec = 0;
  int n_err = 0;

  mem_block_mover #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_data(fill_data),
    .busy(busy), .done(done), .words_done(words_done),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write_en) mem[mem_addr] <= mem_write_data;
  assign mem_read_data = mem[mem_addr];

  task automatic expect_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic check_mem(input string tag);
    for (int k = 0; k < 16; k++) expect_eq($sformatf("%s_mem%0d", tag, k), mem[k], ref_mem[k]);
  endtask

  // Runs one transfer; operand inputs are scrambled after the start edge and an
  // optional stray start is pulsed at cycle restart_at to prove both are ignored.
  task automatic run_op(input string tag, input bit m, input logic [3:0] s, input logic [3:0] d,
                        input logic [4:0] len, input logic [7:0] f, input int restart_at);
    int n, exp_lat, cyc, writes, busy_cyc;
    bit seen;
    n = (len > 16) ? 16 : int'(len);
    exp_lat = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; length = len; fill_data = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    src_addr = 4'($urandom); dst_addr = 4'($urandom); length = 5'($urandom);
    fill_data = 8'($urandom); mode = ~m;
    cyc = 0; writes = 0; busy_cyc = 0; seen = 0;
    while (!seen && cyc < 80) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      if (mem_write_en) writes++;
      if (busy) busy_cyc++;
      if (done) seen = 1;
    end
    start = 1'b0;
    expect_eq({tag, "_latency"}, cyc, exp_lat);
    expect_eq({tag, "_writes"}, writes, n);
    expect_eq({tag, "_busy_cycles"}, busy_cyc, exp_lat - 1);
    expect_eq({tag, "_words_done"}, words_done, n);
    for (int k = 0; k < n; k++)
      ref_mem[(int'(d) + k) % 16] = m ? f : ref_mem[(int'(s) + k) % 16];
    @(negedge clk);
    expect_eq({tag, "_done_once"}, done, 0);
    expect_eq({tag, "_wd_hold"}, words_done, n);
    expect_eq({tag, "_idle_addr"}, mem_addr, 0);
    check_mem(tag);
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < 16; k++) poke(k, 8'($urandom));
    #12;
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_done", done, 0);
    expect_eq("rst_wd", words_done, 0);
    expect_eq("rst_we", mem_write_en, 0);
    expect_eq("rst_addr", mem_addr, 0);
    expect_eq("rst_wdata", mem_write_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    poke(2, 8'hAA); poke(3, 8'hBB); poke(4, 8'hCC);
    run_op("copy3", 1'b0, 4'd2, 4'd8, 5'd3, 8'h00, 0);
    expect_eq("copy3_m8", mem[8], 8'hAA);
    expect_eq("copy3_m10", mem[10], 8'hCC);

    run_op("fillwrap", 1'b1, 4'd0, 4'd14, 5'd4, 8'h5A, 0);
    expect_eq("fillwrap_m1", mem[1], 8'h5A);

    run_op("zero", 1'b0, 4'd3, 4'd5, 5'd0, 8'h77, 0);
    run_op("clamp", 1'b1, 4'd0, 4'd0, 5'd20, 8'h11, 3);

    poke(0, 8'd1); poke(1, 8'd2); poke(2, 8'd3); poke(3, 8'd4);
    run_op("overlap", 1'b0, 4'd0, 4'd1, 5'd3, 8'h00, 0);
    expect_eq("overlap_m3", mem[3], 1);

    // Reset during the second WR: only the first word may land.
    @(negedge clk);
    mode = 1'b0; src_addr = 4'd0; dst_addr = 4'd8; length = 5'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    repeat (4) begin @(negedge clk); cyc++; end
    expect_eq("midrst_wr2", mem_write_en, 1);
    rst_n = 1'b0;
    #1;
    expect_eq("midrst_busy", busy, 0);
    expect_eq("midrst_we", mem_write_en, 0);
    expect_eq("midrst_addr", mem_addr, 0);
    expect_eq("midrst_wdata", mem_write_data, 0);
    expect_eq("midrst_wd", words_done, 0);
    ref_mem[8] = ref_mem[0];
    @(negedge clk);
    rst_n = 1'b1;
    check_mem("midrst");
    run_op("afterrst", 1'b0, 4'd0, 4'd8, 5'd4, 8'h00, 0);

    for (int t = 0; t < 10; t++)
      run_op($sformatf("rnd%0d", t), 1'($urandom), 4'($urandom), 4'($urandom),
             5'($urandom_range(0, 20)), 8'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
